// File: rtl/fb_pkg.sv
// Shared types and geometry helpers for the double-buffered frame-buffer
// controller. Optional build macro: FB_CLEAR_EN (adds the back-page fill state).
package fb_pkg;

    localparam int DEF_H_RES = 640;
    localparam int DEF_V_RES = 480;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_CAP,
        ST_WR_SETUP,
        ST_WR_PULSE
`ifdef FB_CLEAR_EN
        , ST_CLR
`endif
    } fb_state_t;

    // Pixels packed into one 16-bit SRAM word: one per byte lane, or a full word.
    function automatic int fb_ppw(input int pix_bits);
        return (pix_bits <= 8) ? 2 : 1;
    endfunction

    // SRAM words occupied by one display line.
    function automatic int fb_wpl(input int h_res, input int pix_bits);
        return h_res / fb_ppw(pix_bits);
    endfunction

    // Word offset of pixel (x, y) inside a page; the page bit is added by the caller.
    function automatic logic [19:0] fb_word_offset(input logic [9:0] x, input logic [9:0] y,
                                                   input int h_res, input int pix_bits);
        int ppw;
        ppw = fb_ppw(pix_bits);
        return 20'(int'(y) * fb_wpl(h_res, pix_bits) + int'(x) / ppw);
    endfunction

endpackage

// File: rtl/fb_if.sv
// Pixel-write handshake between the drawing engine (master) and the
// frame-buffer controller (slave).
interface fb_if #(
    parameter int PIX_BITS = 4
);
    logic                save_valid;
    logic                save_ready;
    logic [9:0]          SaveX;
    logic [9:0]          SaveY;
    logic [PIX_BITS-1:0] save_color;

    modport master (output save_valid, SaveX, SaveY, save_color, input save_ready);
    modport slave  (input save_valid, SaveX, SaveY, save_color, output save_ready);
endinterface

// File: rtl/fb_line_buf.sv
// Two-bank display line buffer: one SRAM word written per fetch step, one
// pixel read per clock with byte-lane select and a registered output.
module fb_line_buf #(
    parameter int PIX_BITS = 4,
    parameter int WPL      = 320,
    parameter int IW       = $clog2(WPL)
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                wr_en,
    input  logic                wr_bank,
    input  logic [IW-1:0]       wr_idx,
    input  logic [15:0]         wr_data,
    input  logic                rd_en,
    input  logic                rd_bank,
    input  logic [IW-1:0]       rd_idx,
    input  logic                rd_lane,
    output logic [PIX_BITS-1:0] rd_pix
);
    logic [15:0]         mem [2][WPL];
    logic [15:0]         rd_word;
    logic [7:0]          lane_byte;
    logic [PIX_BITS-1:0] pix_sel;

    // Store one fetched SRAM word into the selected bank.
    // NOTE: the storage array has no reset; it is always rewritten by a fetch
    // before being displayed, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge Clk) begin
        if (wr_en) mem[wr_bank][wr_idx] <= wr_data;
    end

    // Pick the addressed word and the pixel lane within it.
    always_comb begin
        rd_word   = mem[rd_bank][rd_idx];
        lane_byte = rd_lane ? rd_word[15:8] : rd_word[7:0];
        pix_sel   = (PIX_BITS <= 8) ? PIX_BITS'(lane_byte) : PIX_BITS'(rd_word);
    end

    // Registered pixel output; blank outside the active area.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) rd_pix <= '0;
        else       rd_pix <= rd_en ? pix_sel : '0;
    end
endmodule

// File: rtl/frame_buffer_ctrl.sv
// Double-buffered SRAM frame-buffer controller: pixel writes to the back page,
// line prefetch from the front page, registered pixel output, frame-synchronous
// page flip. Optional build macro: FB_CLEAR_EN (back-page fill with clear_color).
module frame_buffer_ctrl
    import fb_pkg::*;
#(
    parameter int H_RES    = DEF_H_RES,
    parameter int V_RES    = DEF_V_RES,
    parameter int PIX_BITS = 4,
    parameter int PAGE_BIT = 19
) (
    input  logic                Clk,
    input  logic                Reset,
    fb_if.slave                 save,
    input  logic                flip_req,
    input  logic                frame_start,
    output logic                flip_done,
    output logic                disp_page,
    input  logic                line_req,
    input  logic [9:0]          line_y,
    output logic                line_busy,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          DrawY,
    output logic [PIX_BITS-1:0] pix_out,
`ifdef FB_CLEAR_EN
    input  logic                clear_req,
    input  logic [PIX_BITS-1:0] clear_color,
    output logic                clear_busy,
`endif
    output logic [19:0]         SRAM_ADDR,
    inout  wire  [15:0]         SRAM_DQ,
    output logic                SRAM_CE_N,
    output logic                SRAM_OE_N,
    output logic                SRAM_WE_N,
    output logic                SRAM_UB_N,
    output logic                SRAM_LB_N
);
    localparam int PPW = fb_ppw(PIX_BITS);
    localparam int WPL = fb_wpl(H_RES, PIX_BITS);
    localparam int IW  = $clog2(WPL);
    localparam logic [9:0] H_MAX = 10'(H_RES);
    localparam logic [9:0] V_MAX = 10'(V_RES);

    fb_state_t   state, state_n;
    logic [19:0] addr_q;
    logic [15:0] wr_data_q, dq_out;
    logic        wr_odd_q, dq_oe;
    logic        fetch_pending, fetch_bank;
    logic [9:0]  pend_y, fetch_y_sel;
    logic [IW-1:0] word_idx;
    logic        want_fetch, start_fetch, last_word;
    logic        in_range, wr_go;
    logic        flip_pending, flip_take, disp_page_n;
    logic        clr_block;

    function automatic logic [19:0] page_addr(input logic page, input logic [19:0] off);
        logic [19:0] a;
        a           = off;
        a[PAGE_BIT] = page;
        return a;
    endfunction

    function automatic logic [15:0] pack_pix(input logic [PIX_BITS-1:0] c);
        if (PPW == 2) return {8'(c), 8'(c)};
        else          return 16'(c);
    endfunction

    assign want_fetch  = line_req || fetch_pending;
    assign fetch_y_sel = line_req ? line_y : pend_y;
    assign start_fetch = (state == ST_IDLE) && want_fetch;
    assign last_word   = (word_idx == IW'(WPL - 1));
    assign in_range    = (save.SaveX < H_MAX) && (save.SaveY < V_MAX);
    assign save.save_ready = !Reset && (state == ST_IDLE) && !want_fetch && !clr_block;
    assign wr_go       = save.save_valid && save.save_ready && in_range;
    assign line_busy   = fetch_pending || (state == ST_RD_ADDR) || (state == ST_RD_CAP);
    assign flip_take   = frame_start && (flip_pending || flip_req);
    assign disp_page_n = disp_page ^ flip_take;
    assign SRAM_ADDR   = addr_q;
    assign SRAM_CE_N   = 1'b0;
    assign SRAM_DQ     = dq_oe ? dq_out : 'z;

`ifdef FB_CLEAR_EN
    localparam int NWORDS = WPL * V_RES;
    localparam int CW     = $clog2(NWORDS);
    logic          clear_active, clr_phase, clr_last;
    logic [CW-1:0] clr_idx;
    logic [15:0]   clr_data_q;

    assign clr_last   = (clr_idx == CW'(NWORDS - 1));
    assign clr_block  = clear_active;
    assign clear_busy = clear_active;

    // Fill bookkeeping: word counter, setup/pulse phase and latched fill value.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            clear_active <= 1'b0;
            clr_phase    <= 1'b0;
            clr_idx      <= '0;
            clr_data_q   <= '0;
        end else begin
            if (clear_req && !clear_active) begin
                clear_active <= 1'b1;
                clr_idx      <= '0;
                clr_data_q   <= pack_pix(clear_color);
            end else if (state == ST_CLR && clr_phase) begin
                clr_idx <= clr_idx + 1'b1;
                if (clr_last) clear_active <= 1'b0;
            end
            clr_phase <= (state == ST_CLR) ? ~clr_phase : 1'b0;
        end
    end
`else
    assign clr_block = 1'b0;
`endif

    // State register; reset aborts any access at once since strobes decode state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    // Next state and SRAM strobes decoded from the current state.
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_n   = state;
        SRAM_OE_N = 1'b1;
        SRAM_WE_N = 1'b1;
        SRAM_UB_N = 1'b1;
        SRAM_LB_N = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = wr_data_q;
        case (state)
            ST_IDLE: begin
                if (want_fetch)     state_n = ST_RD_ADDR;
`ifdef FB_CLEAR_EN
                else if (clear_active) state_n = ST_CLR;
`endif
                else if (wr_go)     state_n = ST_WR_SETUP;
            end
            ST_RD_ADDR, ST_RD_CAP: begin
                SRAM_OE_N = 1'b0;
                SRAM_UB_N = 1'b0;
                SRAM_LB_N = 1'b0;
                if (state == ST_RD_ADDR) state_n = ST_RD_CAP;
                else                     state_n = last_word ? ST_IDLE : ST_RD_ADDR;
            end
            ST_WR_SETUP, ST_WR_PULSE: begin
                dq_oe     = 1'b1;
                SRAM_UB_N = !((PPW == 1) || wr_odd_q);
                SRAM_LB_N = !((PPW == 1) || !wr_odd_q);
                if (state == ST_WR_PULSE) begin
                    SRAM_WE_N = 1'b0;
                    state_n   = ST_IDLE;
                end else begin
                    state_n   = ST_WR_PULSE;
                end
            end
`ifdef FB_CLEAR_EN
            ST_CLR: begin
                dq_oe     = 1'b1;
                dq_out    = clr_data_q;
                SRAM_UB_N = 1'b0;
                SRAM_LB_N = 1'b0;
                SRAM_WE_N = ~clr_phase;
                if (clr_phase && (clr_last || want_fetch)) state_n = ST_IDLE;
            end
`endif
            default: state_n = ST_IDLE;
        endcase
    end

    // Address, write data and line-fetch bookkeeping.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            addr_q        <= '0;
            wr_data_q     <= '0;
            wr_odd_q      <= 1'b0;
            fetch_pending <= 1'b0;
            fetch_bank    <= 1'b0;
            pend_y        <= '0;
            word_idx      <= '0;
        end else begin
            // The newest line_req wins; a running fetch is never cut short.
            if (start_fetch) begin
                fetch_pending <= 1'b0;
                fetch_bank    <= fetch_y_sel[0];
                word_idx      <= '0;
                addr_q        <= page_addr(disp_page,
                                           fb_word_offset(10'd0, fetch_y_sel, H_RES, PIX_BITS));
            end else if (line_req) begin
                fetch_pending <= 1'b1;
                pend_y        <= line_y;
            end
            if (wr_go) begin
                addr_q    <= page_addr(~disp_page,
                                       fb_word_offset(save.SaveX, save.SaveY, H_RES, PIX_BITS));
                wr_data_q <= pack_pix(save.save_color);
                wr_odd_q  <= save.SaveX[0];
            end
            if (state == ST_RD_CAP && !last_word) begin
                addr_q   <= addr_q + 20'd1;
                word_idx <= word_idx + 1'b1;
            end
`ifdef FB_CLEAR_EN
            // The fill address follows the back page as it is after any flip this cycle.
            if (state == ST_IDLE && state_n == ST_CLR)
                addr_q <= page_addr(~disp_page_n, 20'(clr_idx));
            else if (state == ST_CLR && clr_phase && state_n == ST_CLR)
                addr_q <= page_addr(~disp_page_n, 20'(clr_idx + 1'b1));
`endif
        end
    end

    // Page flip: merge requests, swap on the frame boundary, pulse done.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            flip_pending <= 1'b0;
            disp_page    <= 1'b0;
            flip_done    <= 1'b0;
        end else begin
            disp_page <= disp_page_n;
            flip_done <= flip_take;
            if (flip_take)     flip_pending <= 1'b0;
            else if (flip_req) flip_pending <= 1'b1;
        end
    end

    fb_line_buf #(
        .PIX_BITS (PIX_BITS),
        .WPL      (WPL),
        .IW       (IW)
    ) u_line_buf (
        .Clk     (Clk),
        .Reset   (Reset),
        .wr_en   (state == ST_RD_CAP),
        .wr_bank (fetch_bank),
        .wr_idx  (word_idx),
        .wr_data (SRAM_DQ),
        .rd_en   ((DrawX < H_MAX) && (DrawY < V_MAX)),
        .rd_bank (DrawY[0]),
        .rd_idx  (IW'(int'(DrawX) / PPW)),
        .rd_lane ((PPW == 2) ? DrawX[0] : 1'b0),
        .rd_pix  (pix_out)
    );
endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Directed bench for frame_buffer_ctrl (default build) with a behavioural SRAM.
module tb_frame_buffer_ctrl;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        flip_req, frame_start, flip_done, disp_page;
    logic        line_req, line_busy;
    logic [9:0]  line_y, DrawX, DrawY;
    logic [3:0]  pix_out;
    logic [19:0] SRAM_ADDR;
    wire  [15:0] sram_dq;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

    int n_vec = 0;
    int n_err = 0;
    int we_cnt = 0;
    int busy_cnt;

    logic [15:0] mem [0:(1<<20)-1];

    fb_if #(.PIX_BITS(4)) sv_if ();

    frame_buffer_ctrl dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .save        (sv_if),
        .flip_req    (flip_req),
        .frame_start (frame_start),
        .flip_done   (flip_done),
        .disp_page   (disp_page),
        .line_req    (line_req),
        .line_y      (line_y),
        .line_busy   (line_busy),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .pix_out     (pix_out),
        .SRAM_ADDR   (SRAM_ADDR),
        .SRAM_DQ     (sram_dq),
        .SRAM_CE_N   (SRAM_CE_N),
        .SRAM_OE_N   (SRAM_OE_N),
        .SRAM_WE_N   (SRAM_WE_N),
        .SRAM_UB_N   (SRAM_UB_N),
        .SRAM_LB_N   (SRAM_LB_N)
    );

    always #10 Clk = ~Clk;

    // Asynchronous SRAM: drives the bus while OE_N is low, stores lanes on WE_N low.
    assign sram_dq = (!SRAM_CE_N && !SRAM_OE_N) ? mem[SRAM_ADDR] : 16'hzzzz;

    always @(posedge Clk) begin
        if (!SRAM_CE_N && !SRAM_WE_N) begin
            we_cnt = we_cnt + 1;
            if (!SRAM_UB_N) mem[SRAM_ADDR][15:8] = sram_dq[15:8];
            if (!SRAM_LB_N) mem[SRAM_ADDR][7:0]  = sram_dq[7:0];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge Clk);
        #1;
    endtask

    task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y, input logic [3:0] exp);
        DrawX = x;
        DrawY = y;
        step();
        check(tag, 32'(pix_out), 32'(exp));
    endtask

    initial begin
        Reset = 1'b1;
        flip_req = 0; frame_start = 0; line_req = 0; line_y = 0; DrawX = 0; DrawY = 0;
        sv_if.save_valid = 0; sv_if.SaveX = 0; sv_if.SaveY = 0; sv_if.save_color = 0;
        mem[20'd1600]    = 16'h0B0C;   // page 0, line 5, word 0
        mem[20'd1919]    = 16'h0708;   // page 0, line 5, word 319
        mem[20'h80001]   = 16'h1111;   // target of the aborted write

        // Reset state
        repeat (3) step();
        check("rst_ready", 32'(sv_if.save_ready), 32'd0);
        check("rst_strobes", 32'({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}), 32'b01111);
        check("rst_outs", 32'({disp_page, flip_done, line_busy, pix_out}), 32'd0);
        check("rst_addr", 32'(SRAM_ADDR), 32'd0);
        @(negedge Clk); Reset = 1'b0; #1;
        check("ready_after_rst", 32'(sv_if.save_ready), 32'd1);

        // Write X=3 Y=2 color A -> page 1, word 2*320+1, high lane
        sv_if.save_valid = 1; sv_if.SaveX = 10'd3; sv_if.SaveY = 10'd2; sv_if.save_color = 4'hA;
        step();
        sv_if.save_valid = 0;
        check("wr_setup_ready", 32'(sv_if.save_ready), 32'd0);
        check("wr_setup_addr", 32'(SRAM_ADDR), 32'h80281);
        check("wr_setup_lanes", 32'({SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}), 32'b101);
        check("wr_setup_dq", 32'(sram_dq[15:8]), 32'h0A);
        step();
        check("wr_pulse_we", 32'({SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}), 32'b001);
        check("wr_pulse_ready", 32'(sv_if.save_ready), 32'd0);
        step();
        check("wr_ready_back", 32'(sv_if.save_ready), 32'd1);
        check("wr_mem", 32'(mem[20'h80281][15:8]), 32'h0A);

        // Out-of-range writes: accepted, dropped, no SRAM cycle
        sv_if.save_valid = 1; sv_if.SaveX = 10'd640; sv_if.SaveY = 10'd0;
        step();
        check("oor_x_ready", 32'(sv_if.save_ready), 32'd1);
        sv_if.SaveX = 10'd0; sv_if.SaveY = 10'd480;
        step();
        check("oor_y_ready", 32'(sv_if.save_ready), 32'd1);
        sv_if.save_valid = 0;
        step(); step();
        check("oor_addr", 32'(SRAM_ADDR), 32'h80281);
        check("oor_we_cnt", 32'(we_cnt), 32'd1);

        // Line fetch of y=5 racing a save: fetch wins, save follows
        @(negedge Clk);
        line_req = 1; line_y = 10'd5;
        sv_if.save_valid = 1; sv_if.SaveX = 10'd4; sv_if.SaveY = 10'd3; sv_if.save_color = 4'h5;
        #1;
        check("prio_ready_low", 32'(sv_if.save_ready), 32'd0);
        check("prio_busy_low", 32'(line_busy), 32'd0);
        @(negedge Clk); line_req = 0; #1;
        busy_cnt = 0;
        for (int i = 0; i < 2000 && line_busy; i++) begin
            busy_cnt++;
            step();
        end
        check("fetch_busy_cycles", 32'(busy_cnt), 32'd640);
        check("fetch_busy_done", 32'(line_busy), 32'd0);
        check("prio_ready_after", 32'(sv_if.save_ready), 32'd1);
        step();
        sv_if.save_valid = 0;
        check("prio_wr_addr", 32'(SRAM_ADDR), 32'h803C2);
        check("prio_wr_lanes", 32'({SRAM_UB_N, SRAM_LB_N}), 32'b10);
        check("prio_wr_dq", 32'(sram_dq[7:0]), 32'h05);
        step(); step();

        // Pixel reads from bank 1 (line 5)
        pix("pix_x1", 10'd1, 10'd5, 4'hB);
        pix("pix_x0", 10'd0, 10'd5, 4'hC);
        pix("pix_x639", 10'd639, 10'd5, 4'h7);
        pix("pix_x638", 10'd638, 10'd5, 4'h8);
        pix("pix_x640", 10'd640, 10'd5, 4'h0);
        pix("pix_y480", 10'd1, 10'd481, 4'h0);

        // Two merged flip requests, then frame_start
        @(negedge Clk); flip_req = 1;
        @(negedge Clk); flip_req = 0;
        @(negedge Clk); flip_req = 1;
        @(negedge Clk); flip_req = 0; #1;
        check("flip_wait_page", 32'({disp_page, flip_done}), 32'b00);
        @(negedge Clk); frame_start = 1;
        step();
        frame_start = 0;
        check("flip_page", 32'(disp_page), 32'd1);
        check("flip_done_pulse", 32'(flip_done), 32'd1);
        step();
        check("flip_done_single", 32'({disp_page, flip_done}), 32'b10);

        // Writes now land in page 0
        sv_if.save_valid = 1; sv_if.SaveX = 10'd0; sv_if.SaveY = 10'd0; sv_if.save_color = 4'h3;
        step();
        sv_if.save_valid = 0;
        check("p0_wr_addr", 32'(SRAM_ADDR), 32'h00000);
        check("p0_wr_lanes", 32'({SRAM_UB_N, SRAM_LB_N}), 32'b10);
        step(); step();

        // frame_start with nothing pending, then request and frame_start together
        frame_start = 1;
        step();
        frame_start = 0;
        check("noflip", 32'({disp_page, flip_done}), 32'b10);
        flip_req = 1; frame_start = 1;
        step();
        flip_req = 0; frame_start = 0;
        check("sameflip", 32'({disp_page, flip_done}), 32'b01);

        // Reset during WR_PULSE aborts the write
        sv_if.save_valid = 1; sv_if.SaveX = 10'd2; sv_if.SaveY = 10'd0; sv_if.save_color = 4'h9;
        step();
        sv_if.save_valid = 0;
        check("abort_addr", 32'(SRAM_ADDR), 32'h80001);
        step();
        check("abort_we_low", 32'(SRAM_WE_N), 32'd0);
        #2 Reset = 1'b1;
        #1;
        check("abort_we_high", 32'(SRAM_WE_N), 32'd1);
        check("abort_ready", 32'(sv_if.save_ready), 32'd0);
        @(negedge Clk); @(negedge Clk); Reset = 1'b0; #1;
        check("abort_mem", 32'(mem[20'h80001]), 32'h1111);
        check("abort_we_cnt", 32'(we_cnt), 32'd3);
        check("abort_ready_back", 32'(sv_if.save_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
